xadc_packetizer: RTL and testbench
==================================

# xadc_packetizer

Parametrised successor to the fixed-pattern byte generator on the CMOD/FT232H path. The block watches the XADC wizard's end-of-conversion strobe and reads each enabled channel's result over the DRP. It buffers `{channel, sample}` entries in an internal FIFO and serialises each entry as a framed byte packet onto an AXI-Stream byte sink that feeds `ft232h.sys_axis`. The block sits between `xadc_wiz_0` and the USB FIFO bridge, in the `sys_clk` domain.

## Interface
- `CHANNEL_MASK`, default `32'h1010_0000`: XADC channel numbers to capture, one bit per channel. The default enables VAUX4 (0x14) and VAUX12 (0x1C).
- `DEPTH`, default 16: FIFO entries. Must be a power of 2, at least 2.
- `DRP_TIMEOUT`, default 63: cycles to wait for `drdy` before abandoning a read. Range 1..255.
- `clk` in 1: system clock, the 12 MHz `sys_clk`.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when low, `eoc` is ignored. Work already in flight completes.
- `eoc` in 1: XADC `eoc_out`.
- `channel` in 5: XADC `channel_out`, valid when `eoc`=1.
- `den` out 1: DRP enable, one-cycle pulse.
- `dwe` out 1: DRP write enable, tied 0.
- `daddr` out 7: DRP address, `{2'b00, channel}`.
- `di` out 16: tied 0.
- `drdy` in 1: DRP data ready.
- `do_data` in 16: DRP read data. The sample is `do_data[15:4]`.
- `m_axis_tdata` out 8: byte stream to `ft232h`.
- `m_axis_tvalid` out 1: byte valid.
- `m_axis_tready` in 1: sink ready.
- `m_axis_tlast` out 1: high on the final byte of each packet.
- `drop_count` out 16: saturating count of lost samples.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Reset values:** `den`=0, `daddr`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `drop_count`=0, `fifo_level`=0. Both FSMs are in IDLE. The sequence counter is 0.
- **Capture FSM**
  - IDLE → REQ when `enable && eoc && CHANNEL_MASK[channel]`. The channel is latched.
  - REQ: `den`=1 for exactly one cycle, with `daddr` set. → WAIT.
  - WAIT → IDLE when `drdy`=1. `{ch, do_data[15:4]}` is pushed to the FIFO.
  - WAIT → IDLE after `DRP_TIMEOUT` cycles without `drdy`. Nothing is pushed and `drop_count` increments.
- **Capture boundary conditions**
  - `eoc` for a masked-off channel is ignored.
  - A qualifying `eoc` that arrives while the FSM is in REQ or WAIT increments `drop_count` and is not queued.
  - A push while the FIFO is full is discarded and increments `drop_count`.
  - `drop_count` saturates at 16'hFFFF.
  - If two drop events occur in the same cycle, `drop_count` increments by 1 only.
- **FIFO:** circular buffer, pointer width $clog2(DEPTH)+1.
  - Full when the pointers differ only in their MSB.
  - A simultaneous push and pop while full is allowed, because the pop frees the slot in the same cycle. The push is not dropped.
- **Serializer FSM:** IDLE → B0 → B1 → B2 → IDLE. With the sequence feature enabled, the path is B0 → B1 → B2 → B3 → IDLE.
  - In IDLE with the FIFO non-empty, the FSM pops one entry into a holding register and goes to B0.
  - B0 = `{3'b101, ch[4:0]}`.
  - B1 = `{4'b0000, sample[11:8]}`.
  - B2 = `sample[7:0]`.
  - The FSM advances only on `m_axis_tvalid && m_axis_tready`.
  - `tdata` and `tlast` hold steady while `tvalid && !tready`.
  - `tvalid` stays high from B0 until the final byte is accepted.
- **Reset mid-operation:** any partial packet is discarded with no trailing bytes. FIFO contents are lost.

## Timing
- `eoc` high in cycle N → `den` high in cycle N+1.
- `drdy` high in cycle M → entry present in the FIFO from cycle M+1. If the serializer is idle, `m_axis_tvalid` goes high with B0 in cycle M+2.
- With `tready` held at 1, one byte is accepted per cycle: a packet takes 3 cycles, or 4 with the sequence feature enabled.
- The next packet's B0 appears 2 cycles after the previous `tlast` handshake: one cycle in IDLE for the pop, then B0.
- The DRP timeout counter starts in the first WAIT cycle and expires after exactly `DRP_TIMEOUT` WAIT cycles.
- `fifo_level` is registered and reflects pushes and pops of the previous cycle.

## Configuration
- Macro: `XADC_PACKETIZER_SEQ_EN`.
- **Defined:**
  - Each packet carries a fourth byte B3 = 8-bit sequence number.
  - `tlast` is on B3.
  - The sequence number increments, wrapping 255→0, on each completed packet. The host uses it to detect loss.
- **Undefined:**
  - Packets are 3 bytes with `tlast` on B2.
  - No sequence counter is built.

## Test plan
- **Single sample:** `CHANNEL_MASK` default, `eoc` with `channel`=0x14, `drdy` 3 cycles later with `do_data`=16'hABC0 → `den` pulse with `daddr`=7'h14, then bytes 0xB4, 0x0A, 0xBC, `tlast` on 0xBC. With `XADC_PACKETIZER_SEQ_EN`, a 4th byte 0x00.
- **Masked channel:** `eoc` with `channel`=0x03 → no `den`, no output, `drop_count`=0.
- **Back-pressure:** `tready` low for 10 cycles mid-packet → `tdata` stable, no byte lost or duplicated. `DEPTH`=4 with 6 samples queued while stalled → `drop_count`=2, `fifo_level`=4.
- **DRP timeout:** `eoc` on 0x1C, `drdy` never asserted → return to IDLE after 63 WAIT cycles, `drop_count`=1, no packet emitted.
- **Busy drop and wrap:** `eoc` arrives during WAIT → `drop_count`+1. 300 packets with `XADC_PACKETIZER_SEQ_EN` → sequence byte runs 0..255, then 0..43.
- **Reset mid-packet:** assert `rst` after B1 is accepted → next cycle `tvalid`=0, `fifo_level`=0. After release, a new sample produces a clean packet starting at B0.

Source files
------------

// File: rtl/xadc_packetizer.sv
// xadc_packetizer
// Watches the XADC end-of-conversion strobe, reads each enabled channel over
// the DRP, queues {channel, sample} entries in a small FIFO and serialises
// every entry as a framed byte packet on an AXI-Stream byte sink.
//   B0 = {3'b101, ch[4:0]}
//   B1 = {4'h0, sample[11:8]}
//   B2 = sample[7:0]
// Optional feature macro: XADC_PACKETIZER_SEQ_EN
//   defined   -> 4-byte packets, B3 = 8-bit wrapping sequence number, tlast on B3
//   undefined -> 3-byte packets, tlast on B2, no sequence counter
module xadc_packetizer #(
  parameter logic [31:0] CHANNEL_MASK = 32'h1010_0000,
  parameter int          DEPTH        = 16,
  parameter int          DRP_TIMEOUT  = 63
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     eoc_i,
  input  logic [4:0]               channel_i,
  output logic                     den_o,
  output logic                     dwe_o,
  output logic [6:0]               daddr_o,
  output logic [15:0]              di_o,
  input  logic                     drdy_i,
  input  logic [15:0]              do_data_i,
  output logic [7:0]               m_axis_tdata_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     m_axis_tlast_o,
  output logic [15:0]              drop_count_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]    TMO_LAST = 8'(DRP_TIMEOUT - 1);

  typedef struct packed {
    logic [4:0]  ch;
    logic [11:0] smp;
  } entry_t;

  typedef enum logic [1:0] {C_IDLE, C_REQ, C_WAIT} cap_st_t;
  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} ser_st_t;

  // Capture side
  cap_st_t      cap_q;
  logic [4:0]   ch_q;
  logic [7:0]   tmo_q;
  logic         den_q;
  logic [6:0]   daddr_q;

  // FIFO
  entry_t       mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q, lvl_q;
  entry_t       head;
  logic         full, empty;

  // Serializer
  ser_st_t      ser_q;
  logic [11:0]  smp_q;
  logic [7:0]   tdata_q;
  logic         tvalid_q, tlast_q;
  logic [7:0]   seq_byte;

  // Event strobes
  logic         eoc_hit, push, push_ok, pop, acc;
  logic         busy_drop, tmo_drop, full_drop, drop_any;
  logic [15:0]  drop_q;

  // The low nibble of the DRP word carries no sample bits.
  logic         unused_lsb;
  assign unused_lsb = ^do_data_i[3:0];

  assign eoc_hit   = enable_i && eoc_i && CHANNEL_MASK[channel_i];
  assign push      = (cap_q == C_WAIT) && drdy_i;
  assign tmo_drop  = (cap_q == C_WAIT) && !drdy_i && (tmo_q == TMO_LAST);
  assign busy_drop = eoc_hit && (cap_q != C_IDLE);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign full_drop = push && full && !pop;
  assign push_ok   = push && !full_drop;
  assign drop_any  = busy_drop || tmo_drop || full_drop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  assign acc = tvalid_q && m_axis_tready_i;
  assign pop = (ser_q == S_IDLE) && !empty;

  // Capture FSM: latch channel on a qualifying EOC, one-cycle DEN, then wait
  // for DRDY or give up after DRP_TIMEOUT wait cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q   <= C_IDLE;
      ch_q    <= '0;
      tmo_q   <= '0;
      den_q   <= 1'b0;
      daddr_q <= '0;
    end else begin
      den_q <= 1'b0;
      case (cap_q)
        C_IDLE: begin
          if (eoc_hit) begin
            ch_q    <= channel_i;
            daddr_q <= {2'b00, channel_i};
            den_q   <= 1'b1;
            cap_q   <= C_REQ;
          end
        end
        C_REQ: begin
          tmo_q <= '0;
          cap_q <= C_WAIT;
        end
        C_WAIT: begin
          if (drdy_i || (tmo_q == TMO_LAST)) cap_q <= C_IDLE;
          else                               tmo_q <= tmo_q + 8'd1;
        end
        default: cap_q <= C_IDLE;
      endcase
    end
  end

  // FIFO storage: no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= '{ch: ch_q, smp: do_data_i[15:4]};
  end

  // FIFO pointers and registered occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_ONE;
      if (pop)     rd_q <= rd_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   lvl_q <= lvl_q + PTR_ONE;
        2'b01:   lvl_q <= lvl_q - PTR_ONE;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // Lost-sample counter: saturating, at most +1 per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i)                               drop_q <= '0;
    else if (drop_any && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

`ifdef XADC_PACKETIZER_SEQ_EN
  localparam logic LAST_B2 = 1'b0;
  logic [7:0] seq_q;

  // Sequence number advances when a packet's final byte is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i)                        seq_q <= '0;
    else if (ser_q == S_B3 && acc)    seq_q <= seq_q + 8'd1;
  end

  assign seq_byte = seq_q;
`else
  localparam logic LAST_B2 = 1'b1;
  assign seq_byte = 8'h00;
`endif

  // Serializer FSM: pop one entry in IDLE, then step through the bytes on
  // each handshake. Outputs are registered so they hold while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ser_q    <= S_IDLE;
      smp_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      case (ser_q)
        S_IDLE: begin
          if (pop) begin
            smp_q    <= head.smp;
            tdata_q  <= {3'b101, head.ch};
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            ser_q    <= S_B0;
          end
        end
        S_B0: begin
          if (acc) begin
            tdata_q <= {4'h0, smp_q[11:8]};
            ser_q   <= S_B1;
          end
        end
        S_B1: begin
          if (acc) begin
            tdata_q <= smp_q[7:0];
            tlast_q <= LAST_B2;
            ser_q   <= S_B2;
          end
        end
        S_B2: begin
          if (acc) begin
            if (LAST_B2) begin
              tdata_q  <= '0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              ser_q    <= S_IDLE;
            end else begin
              tdata_q  <= seq_byte;
              tlast_q  <= 1'b1;
              ser_q    <= S_B3;
            end
          end
        end
        S_B3: begin
          if (acc) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ser_q    <= S_IDLE;
          end
        end
        default: ser_q <= S_IDLE;
      endcase
    end
  end

  assign den_o           = den_q;
  assign dwe_o           = 1'b0;
  assign daddr_o         = daddr_q;
  assign di_o            = 16'h0000;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign drop_count_o    = drop_q;
  assign fifo_level_o    = lvl_q;

endmodule

// File: tb/tb_xadc_packetizer.sv
// Self-checking bench for xadc_packetizer: bench acts as the XADC/DRP side,
// a transaction-level model predicts packet bytes and drop counts.
module tb_xadc_packetizer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] MASK  = 32'h1010_0000;
`ifdef XADC_PACKETIZER_SEQ_EN
  localparam int PKT = 4;
`else
  localparam int PKT = 3;
`endif

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, eoc = 1'b0;
  logic [4:0]  channel = '0;
  logic        drdy = 1'b0, tready = 1'b0;
  logic [15:0] do_data = '0;
  logic        den, dwe, tvalid, tlast;
  logic [6:0]  daddr;
  logic [15:0] di, drop;
  logic [7:0]  tdata;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  xadc_packetizer #(.CHANNEL_MASK(MASK), .DEPTH(DEPTH), .DRP_TIMEOUT(63)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .eoc_i(eoc), .channel_i(channel),
    .den_o(den), .dwe_o(dwe), .daddr_o(daddr), .di_o(di),
    .drdy_i(drdy), .do_data_i(do_data),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
    .m_axis_tlast_o(tlast), .drop_count_o(drop), .fifo_level_o(level)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { int cyc; logic last; logic [7:0] b; } ent_t;
  ent_t rxq[$];
  ent_t expq[$];
  int   rx_base = 0;

  // Monitor: record handshakes, verify hold-under-stall and single-cycle DEN.
  int         cyc = 0, den_cnt = 0;
  logic       prv_stall = 1'b0, prv_den = 1'b0, prv_last = 1'b0;
  logic [7:0] prv_data = '0;
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (prv_stall) begin
      chk("hold_vld",  32'(tvalid), 32'(1));
      chk("hold_data", 32'(tdata),  32'(prv_data));
      chk("hold_last", 32'(tlast),  32'(prv_last));
    end
    if (den) begin
      den_cnt++;
      chk("den_pulse", 32'(prv_den), 32'(0));
    end
    if (!rst && tvalid && tready) begin
      e.cyc = cyc; e.last = tlast; e.b = tdata;
      rxq.push_back(e);
    end
    prv_stall = !rst && tvalid && !tready;
    prv_den   = den;
    prv_data  = tdata;
    prv_last  = tlast;
  end

  // Reference model state
  int         m_drop = 0, m_fq = 0;
  bit         m_hold = 0;
  logic [7:0] m_seq = '0;
  bit         rand_rdy = 0;

  function automatic logic [31:0] exp_drop();
    return (m_drop > 65535) ? 32'd65535 : 32'(m_drop);
  endfunction

  task automatic exp_byte(input logic [7:0] b, input logic l);
    ent_t e;
    e.cyc = 0; e.last = l; e.b = b;
    expq.push_back(e);
  endtask

  // Packet for sample word d: sample = d[15:4].
  task automatic exp_pkt(input logic [4:0] ch, input logic [15:0] d);
    exp_byte({3'b101, ch}, 1'b0);
    exp_byte({4'h0, d[15:12]}, 1'b0);
`ifdef XADC_PACKETIZER_SEQ_EN
    exp_byte(d[11:4], 1'b0);
    exp_byte(m_seq, 1'b1);
    m_seq = m_seq + 8'd1;
`else
    exp_byte(d[11:4], 1'b1);
`endif
  endtask

  // While the sink is stalled: first sample sits in the serializer, the next
  // DEPTH wait in the FIFO, anything further is lost.
  task automatic stall_push(input logic [4:0] ch, input logic [15:0] d);
    if (!m_hold) begin m_hold = 1; exp_pkt(ch, d); end
    else if (m_fq < DEPTH) begin m_fq++; exp_pkt(ch, d); end
    else m_drop++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (rand_rdy) tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_den(output int n);
    @(negedge clk);
    n = 1;
    while (!den && n < 6) begin @(negedge clk); n++; end
  endtask

  task automatic pulse_eoc(input logic [4:0] ch);
    step(); eoc = 1'b1; channel = ch;
    step(); eoc = 1'b0; channel = 5'($urandom);
  endtask

  // One full capture: EOC, expect DEN next cycle, DRDY dly cycles after DEN.
  // With busy set, a second qualifying EOC lands during the wait.
  task automatic do_sample(input logic [4:0] ch, input logic [15:0] d, input int dly, input bit busy);
    int n;
    pulse_eoc(ch);
    wait_den(n);
    chk("den_lat", 32'(n), 32'(1));
    chk("daddr", 32'(daddr), 32'({2'b00, ch}));
    if (busy) begin
      step(); eoc = 1'b1; channel = 5'h1C;
      step(); eoc = 1'b0;
      repeat (dly - 2) step();
      m_drop++;
    end else begin
      repeat (dly) step();
    end
    drdy = 1'b1; do_data = d;
    step(); drdy = 1'b0; do_data = 16'($urandom);
  endtask

  task automatic wait_rx();
    int n = 0;
    while ((rxq.size() - rx_base) < expq.size() && n < 3000) begin step(); n++; end
    chk("rx_wait", 32'(n < 3000), 32'(1));
  endtask

  task automatic cmp_rx();
    wait_rx();
    repeat (6) step();
    chk("rx_count", 32'(rxq.size() - rx_base), 32'(expq.size()));
    foreach (expq[i]) begin
      if (rx_base + i < rxq.size()) begin
        chk("rx_byte", 32'(rxq[rx_base + i].b),    32'(expq[i].b));
        chk("rx_last", 32'(rxq[rx_base + i].last), 32'(expq[i].last));
      end
    end
    rx_base = rxq.size();
    expq.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ch, mch;
    logic [15:0] d;
    int          n, k, snap, w;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_den",    32'(den),    32'(0));
    chk("rst_daddr",  32'(daddr),  32'(0));
    chk("rst_tvalid", 32'(tvalid), 32'(0));
    chk("rst_tdata",  32'(tdata),  32'(0));
    chk("rst_tlast",  32'(tlast),  32'(0));
    chk("rst_drop",   32'(drop),   32'(0));
    chk("rst_level",  32'(level),  32'(0));
    chk("dwe",        32'(dwe),    32'(0));
    chk("di",         32'(di),     32'(0));
    step(); rst = 1'b0; enable = 1'b1; tready = 1'b1;

    // Single sample, with DRDY two cycles after DEN (three after EOC)
    do_sample(5'h14, 16'hABC0, 2, 0);
    @(negedge clk);
    chk("vld_m1", 32'(tvalid), 32'(0));
    step(); @(negedge clk);
    chk("vld_m2", 32'(tvalid), 32'(1));
    chk("b0_m2",  32'(tdata),  32'(8'hB4));
    exp_pkt(5'h14, 16'hABC0);
    cmp_rx();

    // Masked channel and enable low: no DEN, no drop, no bytes
    snap = den_cnt;
    pulse_eoc(5'h03);
    repeat (6) step();
    chk("mask_den", 32'(den_cnt - snap), 32'(0));
    enable = 1'b0;
    pulse_eoc(5'h14);
    repeat (6) step();
    chk("en_den", 32'(den_cnt - snap), 32'(0));
    enable = 1'b1;
    chk("mask_drop", 32'(drop), exp_drop());
    chk("mask_rx", 32'(rxq.size() - rx_base), 32'(0));

    // DRP timeout: drop count moves 64 cycles after the DEN cycle
    snap = rxq.size();
    pulse_eoc(5'h1C);
    wait_den(n);
    chk("tmo_den", 32'(n), 32'(1));
    k = 0;
    while (drop == 16'(m_drop) && k < 100) begin @(negedge clk); k++; end
    chk("tmo_lat", 32'(k), 32'(64));
    m_drop++;
    chk("tmo_drop", 32'(drop), exp_drop());
    repeat (8) step();
    chk("tmo_nopkt", 32'(rxq.size() - snap), 32'(0));

    // EOC held through the whole wait: busy drop coincides with timeout
    pulse_eoc(5'h1C);
    wait_den(n);
    chk("dual_den", 32'(n), 32'(1));
    step(); eoc = 1'b1; channel = 5'h14;
    repeat (62) step();
    step(); eoc = 1'b0;
    @(negedge clk);
    m_drop += 63;
    chk("dual_drop", 32'(drop), exp_drop());

    // Busy drop while a read completes normally
    d = 16'($urandom);
    do_sample(5'h1C, d, 3, 1);
    exp_pkt(5'h1C, d);
    cmp_rx();
    chk("busy_drop", 32'(drop), exp_drop());

    // Randomized traffic with random sink back-pressure (300 packets)
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      w = 0;
      while (expq.size() > (rxq.size() - rx_base) + PKT && w < 500) begin step(); w++; end
      chk("pace", 32'(w < 500), 32'(1));
      if ($urandom_range(0, 7) == 0) begin
        do mch = 5'($urandom); while (MASK[mch]);
        snap = den_cnt;
        pulse_eoc(mch);
        repeat (3) step();
        chk("rnd_mask", 32'(den_cnt - snap), 32'(0));
      end
      repeat ($urandom_range(0, 3)) step();
      ch = ($urandom_range(0, 1) != 0) ? 5'h14 : 5'h1C;
      d  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) do_sample(ch, d, $urandom_range(2, 4), 1);
      else                           do_sample(ch, d, $urandom_range(1, 4), 0);
      exp_pkt(ch, d);
    end
    cmp_rx();
    chk("rnd_drop", 32'(drop), exp_drop());
    rand_rdy = 0; tready = 1'b1;

    // Back-pressure: one packet in flight, six more samples into DEPTH=4
    tready = 1'b0; m_hold = 0; m_fq = 0;
    for (int i = 0; i < 7; i++) begin
      ch = (i % 2 == 1) ? 5'h14 : 5'h1C;
      d  = 16'($urandom);
      do_sample(ch, d, $urandom_range(1, 3), 0);
      stall_push(ch, d);
    end
    @(negedge clk);
    chk("bp_level", 32'(level), 32'(DEPTH));
    chk("bp_drop",  32'(drop),  exp_drop());
    repeat (4) step();
    tready = 1'b1;
    wait_rx();
    for (int i = rx_base; i + 1 < rxq.size(); i++)
      chk(rxq[i].last ? "gap_pkt" : "gap_byte", 32'(rxq[i + 1].cyc - rxq[i].cyc),
          rxq[i].last ? 32'(2) : 32'(1));
    cmp_rx();
    chk("bp_level0", 32'(level), 32'(0));

    // Reset mid-packet after B1 is accepted
    tready = 1'b0;
    d = 16'($urandom);
    do_sample(5'h1C, d, 1, 0);
    do_sample(5'h14, 16'($urandom), 1, 0);
    step(); tready = 1'b1;
    step();
    step(); tready = 1'b0;
    chk("mid_cnt", 32'(rxq.size() - rx_base), 32'(2));
    if (rxq.size() - rx_base >= 2) begin
      chk("mid_b0", 32'(rxq[rx_base].b),     32'({3'b101, 5'h1C}));
      chk("mid_b1", 32'(rxq[rx_base + 1].b), 32'({4'h0, d[15:12]}));
    end
    rx_base = rxq.size();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("mid_tvalid", 32'(tvalid), 32'(0));
    chk("mid_level",  32'(level),  32'(0));
    chk("mid_drop",   32'(drop),   32'(0));
    m_drop = 0; m_seq = '0; expq.delete();
    tready = 1'b1;
    d = 16'($urandom);
    do_sample(5'h14, d, 2, 0);
    exp_pkt(5'h14, d);
    cmp_rx();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
